// File: rtl/bp_pkg.sv
// Shared types and constants for the direct-mapped BTB with saturating direction counters.
package bp_pkg;
  localparam int BP_ADDR_W  = 32;
  localparam int BP_ENTRIES = 64;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_ADDR_W - BP_IDX_W - 2;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weak taken

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [1:0]           ctr;
  } bp_entry_t;

  // Weak-not-taken / weak-taken seeds generalised to any counter width.
  function automatic logic [31:0] ctr_seed(input int w, input bit alloc);
    logic [31:0] half;
    if (w == 2) return alloc ? 32'(CTR_ALLOC) : 32'(CTR_RESET);
    half = 32'd1 << (w - 1);
    return alloc ? half : half - 32'd1;
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down direction counter for one BTB entry, with clear and load.
module bp_sat_counter #(
  parameter int               CTR_W   = 2,
  parameter logic [CTR_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      ctr_o <= RST_VAL;
    else if (clr_i)  ctr_o <= RST_VAL;
    else if (load_i) ctr_o <= load_val_i;
    else if (en_i) begin
      if (inc_i && ctr_o != '1)       ctr_o <= ctr_o + CTR_W'(1);
      else if (!inc_i && ctr_o != '0) ctr_o <= ctr_o - CTR_W'(1);
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer: zero-latency lookup in IF, trained by ID-stage resolution.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispred_o,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  upd_count_o,
  output logic [CNT_W-1:0]  mispred_count_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_seed(CTR_W, 1'b0));
  localparam logic [CTR_W-1:0] CTR_ALC = CTR_W'(ctr_seed(CTR_W, 1'b1));

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag;
  logic [ENTRIES-1:0][ADDR_W-1:0] target;
  logic [ENTRIES-1:0][CTR_W-1:0]  ctr;

  logic [IDX_W-1:0] idx_l, idx_u;
  logic [TAG_W-1:0] tag_l, tag_u;
  logic             upd_hit, we, alloc, train;
  logic             unused_pc;

  assign idx_l = lookup_pc_i[IDX_W+1:2];
  assign tag_l = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign idx_u = upd_pc_i[IDX_W+1:2];
  assign tag_u = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign unused_pc = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Lookup sees pre-edge table contents; a same-cycle update is not bypassed.
  assign pred_hit_o    = valid[idx_l] && (tag[idx_l] == tag_l);
  assign pred_taken_o  = pred_hit_o && ctr[idx_l][CTR_W-1];
  assign pred_target_o = pred_taken_o ? target[idx_l] : lookup_pc_i + ADDR_W'(4);

  assign mispred_o = upd_valid_i &&
                     ((upd_pred_taken_i != upd_taken_i) ||
                      (upd_taken_i && upd_pred_taken_i && upd_pred_target_i != upd_target_i));

  assign upd_hit = valid[idx_u] && (tag[idx_u] == tag_u);
  assign we      = upd_valid_i && !clear_i;
  assign alloc   = we && !upd_hit && upd_taken_i;
  assign train   = we && upd_hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
      end
    end else if (clear_i) begin
      valid <= '0;
    end else if (alloc) begin
      valid[idx_u]  <= 1'b1;
      tag[idx_u]    <= tag_u;
      target[idx_u] <= upd_target_i;
    end else if (train && upd_taken_i) begin
      target[idx_u] <= upd_target_i;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W), .RST_VAL(CTR_RST)) u_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clear_i),
      .load_i     (alloc && idx_u == IDX_W'(g)),
      .load_val_i (CTR_ALC),
      .en_i       (train && idx_u == IDX_W'(g)),
      .inc_i      (upd_taken_i),
      .ctr_o      (ctr[g])
    );
  end

  // Perf counters run even on clear cycles and stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      upd_count_o     <= '0;
      mispred_count_o <= '0;
    end else if (upd_valid_i) begin
      if (upd_count_o != '1)                  upd_count_o     <= upd_count_o + CNT_W'(1);
      if (mispred_o && mispred_count_o != '1) mispred_count_o <= mispred_count_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset/saturation sequences, randomized run vs model.
module tb_branch_predictor;
  localparam int ADDR_W  = 32;
  localparam int ENTRIES = 64;
  localparam int CNT_W   = 4;
  localparam int CMAX    = 15;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [ADDR_W-1:0] lookup_pc_i = '0;
  logic              pred_hit_o, pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i = 1'b0;
  logic [ADDR_W-1:0] upd_pc_i = '0;
  logic              upd_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_target_i = '0;
  logic              upd_pred_taken_i = 1'b0;
  logic [ADDR_W-1:0] upd_pred_target_i = '0;
  logic              mispred_o;
  logic              clear_i = 1'b0;
  logic [CNT_W-1:0]  upd_count_o, mispred_count_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(2), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .mispred_o(mispred_o), .clear_i(clear_i),
    .upd_count_o(upd_count_o), .mispred_count_o(mispred_count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: entries kept as plain arrays, index/tag by division.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_upd, m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit hit, output bit taken,
                               output logic [31:0] tgt);
    int i;
    i     = idx_of(pc);
    hit   = m_valid[i] && m_tag[i] == tag_of(pc);
    taken = hit && m_ctr[i] >= 2;
    tgt   = taken ? m_tgt[i] : pc + 32'd4;
  endtask

  function automatic bit model_mispred();
    if (!upd_valid_i) return 0;
    if (upd_pred_taken_i != upd_taken_i) return 1;
    return upd_taken_i && upd_pred_target_i != upd_target_i;
  endfunction

  task automatic model_edge();
    int i;
    bit hit;
    i   = idx_of(upd_pc_i);
    hit = m_valid[i] && m_tag[i] == tag_of(upd_pc_i);
    if (upd_valid_i) begin
      if (model_mispred() && m_mis < CMAX) m_mis++;
      if (m_upd < CMAX) m_upd++;
    end
    if (clear_i) begin
      for (int k = 0; k < ENTRIES; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
    end else if (upd_valid_i) begin
      if (hit) begin
        if (upd_taken_i) begin
          m_tgt[i] = upd_target_i;
          if (m_ctr[i] < 3) m_ctr[i]++;
        end else if (m_ctr[i] > 0) m_ctr[i]--;
      end else if (upd_taken_i) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upd_pc_i); m_tgt[i] = upd_target_i; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] uptg, input bit clr);
    lookup_pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_target_i = utg; upd_pred_taken_i = upt; upd_pred_target_i = uptg; clear_i = clr;
  endtask

  // One model-checked cycle: inputs already driven after a negedge.
  task automatic step(input string tag);
    bit hit, taken;
    logic [31:0] tgt;
    #1;
    model_predict(lookup_pc_i, hit, taken, tgt);
    check({tag, " hit"},     32'(pred_hit_o),   32'(hit));
    check({tag, " taken"},   32'(pred_taken_o), 32'(taken));
    check({tag, " target"},  pred_target_o,     tgt);
    check({tag, " mispred"}, 32'(mispred_o),    32'(model_mispred()));
    @(posedge clk_i);
    model_edge();
    #1;
    check({tag, " upd_count"},     32'(upd_count_o),     32'(m_upd));
    check({tag, " mispred_count"}, 32'(mispred_count_o), 32'(m_mis));
  endtask

  typedef struct {
    logic [31:0] pc;
    bit uv; logic [31:0] upc; bit ut; logic [31:0] utg; bit upt; logic [31:0] uptg; bit clr;
    bit hit; bit tak; logic [31:0] tgt; bit mis; int ucnt; int mcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] pc, bit uv, logic [31:0] upc, bit ut, logic [31:0] utg,
                              bit upt, logic [31:0] uptg, bit clr, bit hit, bit tak,
                              logic [31:0] tgt, bit mis, int ucnt, int mcnt);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.upt = upt; v.uptg = uptg;
    v.clr = clr; v.hit = hit; v.tak = tak; v.tgt = tgt; v.mis = mis; v.ucnt = ucnt; v.mcnt = mcnt;
    return v;
  endfunction

  initial begin
    //           lookup        uv  upc          ut  utg          upt uptg         clr hit tak target        mis ucnt mcnt
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 0, 32'h0,   0, 0, 0, 32'h104, 1, 1, 1)); // allocate
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h200, 0, 1, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 2, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 3, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, 1, 1, 32'h200, 0, 4, 1));
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 0, 1, 1, 32'h200, 1, 5, 2)); // 11->10
    vecs.push_back(mk(32'h100, 1, 32'h100, 0, 32'h0,   1, 32'h200, 0, 1, 1, 32'h200, 1, 6, 3)); // 10->01
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 0, 32'h104, 0, 6, 3));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h204, 0, 6, 3)); // alias
    vecs.push_back(mk(32'h200, 1, 32'h200, 1, 32'h400, 0, 32'h0,   0, 0, 0, 32'h204, 1, 7, 4));
    vecs.push_back(mk(32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h104, 0, 7, 4));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h400, 0, 7, 4));
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 32'h500, 0, 32'h0,   0, 0, 0, 32'h304, 1, 8, 5)); // no bypass
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 1, 1, 32'h500, 0, 8, 5));
    vecs.push_back(mk(32'h300, 1, 32'h300, 1, 32'h500, 1, 32'h600, 1, 1, 1, 32'h500, 1, 9, 6)); // clear
    vecs.push_back(mk(32'h300, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h304, 0, 9, 6));
    vecs.push_back(mk(32'h200, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h204, 0, 9, 6));
    vecs.push_back(mk(32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0,   0, 9, 6)); // wrap

    // Reset values with reset held.
    lookup_pc_i = 32'h100;
    #2;
    check("rst hit",    32'(pred_hit_o),   32'h0);
    check("rst taken",  32'(pred_taken_o), 32'h0);
    check("rst target", pred_target_o,     32'h104);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst upd_count",     32'(upd_count_o),     32'h0);
    check("rst mispred_count", 32'(mispred_count_o), 32'h0);

    foreach (vecs[r]) begin
      @(negedge clk_i);
      drive(vecs[r].pc, vecs[r].uv, vecs[r].upc, vecs[r].ut, vecs[r].utg, vecs[r].upt,
            vecs[r].uptg, vecs[r].clr);
      #1;
      check($sformatf("vec%0d hit", r),     32'(pred_hit_o),   32'(vecs[r].hit));
      check($sformatf("vec%0d taken", r),   32'(pred_taken_o), 32'(vecs[r].tak));
      check($sformatf("vec%0d target", r),  pred_target_o,     vecs[r].tgt);
      check($sformatf("vec%0d mispred", r), 32'(mispred_o),    32'(vecs[r].mis));
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d upd_count", r),     32'(upd_count_o),     32'(vecs[r].ucnt));
      check($sformatf("vec%0d mispred_count", r), 32'(mispred_count_o), 32'(vecs[r].mcnt));
    end

    // Counter saturation: 20 mispredicted updates from a fresh reset.
    @(negedge clk_i);
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      drive(32'h1000 + 32'(4 * k), 1, 32'h1000 + 32'(4 * k), k[0], 32'h8000 + 32'(k), !k[0], 32'h0, 0);
      step($sformatf("sat%0d", k));
    end
    check("sat upd_count all-ones",     32'(upd_count_o),     32'hF);
    check("sat mispred_count all-ones", 32'(mispred_count_o), 32'hF);

    // Asynchronous reset mid-operation, then a normal update on the first edge after release.
    @(negedge clk_i);
    drive(32'h1004, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre-reset hit", 32'(pred_hit_o), 32'h1);
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    check("midrst hit",           32'(pred_hit_o),      32'h0);
    check("midrst target",        pred_target_o,        32'h1008);
    check("midrst upd_count",     32'(upd_count_o),     32'h0);
    check("midrst mispred_count", 32'(mispred_count_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(32'h1004, 1, 32'h1004, 1, 32'h2000, 0, 32'h0, 0);
    step("post-release");

    // Randomized traffic over a small set of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] lpc, upc, utg, ptg;
      bit uv, ut, pt, hit, taken, clr;
      logic [31:0] tsel [3];
      tsel[0] = 32'h0; tsel[1] = 32'h1; tsel[2] = 32'h00FF_FFFF;
      lpc = (tsel[$urandom_range(0, 2)] << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      upc = (tsel[$urandom_range(0, 2)] << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      utg = $urandom & 32'hFFFF_FFFC;
      uv  = $urandom_range(0, 9) < 7;
      ut  = $urandom_range(0, 1) == 1;
      clr = $urandom_range(0, 29) == 0;
      model_predict(upc, hit, taken, ptg);
      pt  = taken;
      if ($urandom_range(0, 4) == 0) pt = !pt;
      if ($urandom_range(0, 3) == 0) ptg = utg;
      @(negedge clk_i);
      drive(lpc, uv, upc, ut, utg, pt, ptg, clr);
      step($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
